// File: rtl/chan_readout_arb.sv
// chan_readout_arb: round-robin arbiter granting 2**SIZE digitizer channels bounded bursts
// on the shared readout path. Optional idle-burst watchdog enabled by defining ARB_TIMEOUT_EN.
module chan_readout_arb #(
  parameter int SIZE      = 3,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2**SIZE-1:0]   req,
  input  logic                 xfer,
  output logic [2**SIZE-1:0]   grant,
  output logic [SIZE-1:0]      grant_idx,
  output logic                 busy,
  output logic [7:0]           burst_cnt,
  output logic                 burst_done,
  output logic                 timeout_err
);

  localparam int N = 2**SIZE;
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t          state;
  logic [SIZE-1:0] last;
  logic [SIZE-1:0] win_idx;
  logic [SIZE-1:0] win_lo;
  logic [SIZE-1:0] win_hi;
  logic            found_lo;
  logic            found_hi;
  logic [N-1:0]    win_onehot;
  logic            tmo;
  logic            release_burst;

  // Lowest requester above the last-served channel, else lowest requester overall.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found_lo) begin
        win_lo   = SIZE'(i);
        found_lo = 1'b1;
      end
      if (req[i] && !found_hi && (i > 32'(last))) begin
        win_hi   = SIZE'(i);
        found_hi = 1'b1;
      end
    end
    win_idx = found_hi ? win_hi : win_lo;
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != BURST) || xfer) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + 8'd1;
  end

  assign tmo = (state == BURST) && !xfer && (idle_cnt == TMO_LAST);
`else
  // TIMEOUT only matters with the watchdog; both builds keep one parameter list.
  if (TIMEOUT >= 2) begin : g_no_watchdog
    assign tmo = 1'b0;
  end else begin : g_no_watchdog_lo
    assign tmo = 1'b0;
  end
`endif

  assign release_burst = (state == BURST) &&
                         ((xfer && (burst_cnt == LAST_BEAT)) || !req[grant_idx] || tmo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      burst_cnt   <= '0;
      burst_done  <= 1'b0;
      timeout_err <= 1'b0;
      last        <= '1;
    end else begin
      case (state)
        IDLE: begin
          burst_done  <= 1'b0;
          timeout_err <= 1'b0;
          if (|req) begin
            state     <= BURST;
            grant     <= win_onehot;
            grant_idx <= win_idx;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          // The word on a release cycle still counts, including a coincident req drop.
          if (xfer && (burst_cnt != 8'hFF)) burst_cnt <= burst_cnt + 8'd1;
          if (release_burst) begin
            state       <= GAP;
            grant       <= '0;
            busy        <= 1'b0;
            burst_done  <= 1'b1;
            timeout_err <= tmo;
            last        <= grant_idx;
          end
        end
        GAP: begin
          state       <= IDLE;
          burst_done  <= 1'b0;
          timeout_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_readout_arb.sv
// Self-checking bench for chan_readout_arb: vector table, directed burst sequences and
// randomized traffic against a rotation-search reference model.
module tb_chan_readout_arb;

  localparam int SIZE      = 3;
  localparam int N         = 8;
  localparam int BURST_LEN = 16;
  localparam int TIMEOUT   = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           xfer;
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [SIZE-1:0] grant_idx;
  logic           busy;
  logic [7:0]     burst_cnt;
  logic           burst_done;
  logic           timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner of the current burst (-1 when none), words, idle cycles.
  int m_owner, m_last, m_cnt, m_idle;
  bit m_gap, m_done, m_terr;

  always #5 clk = ~clk;

  chan_readout_arb #(.SIZE(SIZE), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .xfer(xfer),
    .grant(grant), .grant_idx(grant_idx), .busy(busy), .burst_cnt(burst_cnt),
    .burst_done(burst_done), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_tick();
    bit drop, full, wd;
    int c;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_cnt = 0; m_idle = 0;
      m_gap = 0; m_done = 0; m_terr = 0;
    end else if (m_owner >= 0) begin
      drop = !req[m_owner];
      full = xfer && (m_cnt + 1 >= BURST_LEN);
`ifdef ARB_TIMEOUT_EN
      wd = !xfer && (m_idle >= TIMEOUT - 1);
`else
      wd = 1'b0;
`endif
      if (xfer) begin
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_idle = 0;
      end else begin
        m_idle++;
      end
      if (drop || full || wd) begin
        m_last = m_owner; m_owner = -1;
        m_gap = 1; m_done = 1; m_terr = wd;
      end
    end else if (m_gap) begin
      m_gap = 0; m_done = 0; m_terr = 0;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c;
          break;
        end
      end
      m_cnt = 0; m_idle = 0;
    end
  endtask

  // One clock: model follows the same edge, outputs compared 1 time unit later.
  task automatic step();
    logic [21:0] got, exp;
    logic [7:0]  eg;
    @(posedge clk);
    model_tick();
    #1;
    eg  = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    got = {grant, busy ? grant_idx : 3'd0, busy, burst_cnt, burst_done, timeout_err};
    exp = {eg, (m_owner >= 0) ? 3'(m_owner) : 3'd0, m_owner >= 0, 8'(m_cnt), m_done, m_terr};
    check("model", int'(got), int'(exp));
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         xfer;
    logic [7:0] grant;
    int         idx;
    bit         busy;
    int         cnt;
    bit         done;
  } vec_t;

  vec_t tbl[17];

  task automatic run_bursts(input logic [7:0] r, input int exp_order[4], input string tag);
    int free, len;
    rst = 1; req = '0; xfer = 0; step();
    rst = 0; req = r; xfer = 1; step();
    check({tag, " grant latency"}, int'(grant), 1 << exp_order[0]);
    for (int b = 0; b < 4; b++) begin
      free = 0;
      while (!busy && free < 10) begin step(); free++; end
      if (b > 0) check({tag, " grant-free gap"}, free, 2);
      check({tag, " order"}, int'(grant_idx), exp_order[b]);
      len = 0;
      while (busy && len < 40) begin len++; step(); end
      check({tag, " burst cycles"}, len, BURST_LEN);
      check({tag, " final count"}, int'(burst_cnt), BURST_LEN);
      check({tag, " done pulse"}, int'(burst_done), 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, len, seen;
    vec_t v;

    tbl[0]  = '{1, 8'h00, 0, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{0, 8'h08, 0, 8'h08, 3, 1, 0, 0};
    tbl[2]  = '{0, 8'h08, 1, 8'h08, 3, 1, 1, 0};
    tbl[3]  = '{0, 8'h08, 1, 8'h08, 3, 1, 2, 0};
    tbl[4]  = '{0, 8'h08, 0, 8'h08, 3, 1, 2, 0};
    tbl[5]  = '{0, 8'h08, 1, 8'h08, 3, 1, 3, 0};
    tbl[6]  = '{0, 8'h08, 1, 8'h08, 3, 1, 4, 0};
    tbl[7]  = '{0, 8'h00, 1, 8'h00, 0, 0, 5, 1};
    tbl[8]  = '{0, 8'h11, 1, 8'h00, 0, 0, 5, 0};
    tbl[9]  = '{0, 8'h11, 0, 8'h10, 4, 1, 0, 0};
    tbl[10] = '{0, 8'h11, 1, 8'h10, 4, 1, 1, 0};
    tbl[11] = '{0, 8'h01, 0, 8'h00, 0, 0, 1, 1};
    tbl[12] = '{0, 8'h01, 0, 8'h00, 0, 0, 1, 0};
    tbl[13] = '{0, 8'h01, 0, 8'h01, 0, 1, 0, 0};
    tbl[14] = '{1, 8'h01, 0, 8'h00, 0, 0, 0, 0};
    tbl[15] = '{0, 8'h81, 0, 8'h01, 0, 1, 0, 0};
    tbl[16] = '{1, 8'h00, 0, 8'h00, 0, 0, 0, 0};

    rst = 1; req = '0; xfer = 0;
    step();

    // Reset state, then idle with no requests
    rst = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant != '0 || busy || burst_done) seen++;
    end
    check("idle no activity", seen, 0);

    foreach (tbl[i]) begin
      v = tbl[i];
      rst = v.rst; req = v.req; xfer = v.xfer;
      step();
      check($sformatf("tbl[%0d]", i),
            int'({grant, v.busy ? grant_idx : 3'd0, busy, burst_cnt, burst_done}),
            int'({v.grant, 3'(v.idx), v.busy, 8'(v.cnt), v.done}));
    end

    run_bursts(8'h01, '{0, 0, 0, 0}, "single");
    run_bursts(8'h85, '{0, 2, 7, 0}, "rr85");

    // Reset in the middle of a burst
    rst = 1; req = '0; xfer = 0; step();
    rst = 0; req = 8'h04; xfer = 1; step();
    k = 0;
    while (burst_cnt != 8'd7 && k < 20) begin step(); k++; end
    check("midburst count", int'(burst_cnt), 7);
    rst = 1; step();
    check("midburst reset", int'({grant, busy, burst_cnt, burst_done, timeout_err}), 0);
    rst = 0; req = 8'h14; xfer = 0; step();
    check("post-reset grant", int'(grant), 8'h04);
    check("post-reset no done", int'(burst_done), 0);

    // Granted channel never transfers
    rst = 1; req = '0; xfer = 0; step();
    rst = 0; req = 8'h02; step();
    check("stall grant", int'(grant), 8'h02);
    len = 1;
    while (busy && len < 100) begin step(); len++; end
`ifdef ARB_TIMEOUT_EN
    check("watchdog burst cycles", len, TIMEOUT);
    check("watchdog pulses", int'({burst_done, timeout_err}), 3);
`else
    check("no watchdog hold", len, 100);
    check("no watchdog busy", int'({busy, timeout_err}), 2);
`endif

    // Randomized traffic
    rst = 1; req = '0; xfer = 0; step();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) req = 8'($urandom & $urandom);
      xfer = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
